// File: rtl/lcd_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types and constants for the 16x2 HD44780 frame
//                writer: top-level FSM states, byte-transmitter phases,
//                controller command bytes and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Top-level sequencing states
    typedef enum logic [3:0] {
        ST_POWERUP    = 4'd0,
        ST_INIT_FUNC  = 4'd1,
        ST_INIT_DISP  = 4'd2,
        ST_INIT_CLEAR = 4'd3,
        ST_INIT_ENTRY = 4'd4,
        ST_IDLE       = 4'd5,
        ST_ADDR_TOP   = 4'd6,
        ST_WR_TOP     = 4'd7,
        ST_ADDR_BOT   = 4'd8,
        ST_WR_BOT     = 4'd9
    } state_t;

    // Phases of one byte transaction; TX_PWR is the post-reset idle wait
    typedef enum logic [2:0] {
        TX_PWR   = 3'd0,
        TX_IDLE  = 3'd1,
        TX_SETUP = 3'd2,
        TX_EN    = 3'd3,
        TX_WAIT  = 3'd4
    } tx_phase_t;

    // HD44780 command bytes
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, no cursor
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (long wait)
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_ROW0     = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_ROW1     = 8'hC0;  // DDRAM address 0x40

    // Width of a down-counter that must hold (largest count - 1)
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_frame_writer_if
//  Description : Bundle between the host display stage (row buffers in) and
//                the LCD pins / status out of the frame writer.
//                master = host side, slave = frame writer.
//  Revision    : 1.0  initial release
// ============================================================================
interface lcd_frame_writer_if;
    logic [127:0] top;
    logic [127:0] bottom;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         busy;
    logic         frame_done;

    modport master (
        output top, bottom,
        input  lcd_en, lcd_rs, lcd_rw, lcd_data, busy, frame_done
    );

    modport slave (
        input  top, bottom,
        output lcd_en, lcd_rs, lcd_rw, lcd_data, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/lcd_frame_writer_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_byte_tx
//  Description : One HD44780 write cycle: RS/DATA setup with E low, E pulse,
//                then a post-pulse execution wait (long after clear-display).
//                Also times the power-up idle after reset, so the whole design
//                has a single cycle counter. done pulses on the last cycle of
//                the power-up wait and of every transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int EN_CYC      = 12,
    parameter int CMD_CYC     = 600,
    parameter int CLEAR_CYC   = 24000,
    parameter int POWERUP_CYC = 240000
) (
    input  wire logic       clk,
    input  wire logic       nRst,
    input  wire logic       start_i,
    input  wire logic       rs_i,
    input  wire logic [7:0] data_i,
    input  wire logic       long_wait_i,
    output logic            done_o,
    output logic            lcd_en_o,
    output logic            lcd_rs_o,
    output logic [7:0]      lcd_data_o
);

    localparam int CNT_W = cnt_width(SETUP_CYC, EN_CYC, CMD_CYC, CLEAR_CYC, POWERUP_CYC);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_phase_t        phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic             w_cnt_zero;

    assign w_cnt_zero = (cnt_q == '0);

    // Phase sequencing and counter reload; RS/DATA latched only at start
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;
        case (phase_q)
            TX_PWR: begin
                if (w_cnt_zero) phase_d = TX_IDLE;
                else            cnt_d   = cnt_q - CNT_ONE;
            end
            TX_IDLE: begin
                if (start_i) begin
                    phase_d = TX_SETUP;
                    cnt_d   = SETUP_LD;
                    rs_d    = rs_i;
                    data_d  = data_i;
                    long_d  = long_wait_i;
                end
            end
            TX_SETUP: begin
                if (w_cnt_zero) begin
                    phase_d = TX_EN;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            TX_EN: begin
                if (w_cnt_zero) begin
                    phase_d = TX_WAIT;
                    cnt_d   = long_q ? CLEAR_LD : CMD_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            TX_WAIT: begin
                if (w_cnt_zero) phase_d = TX_IDLE;
                else            cnt_d   = cnt_q - CNT_ONE;
            end
            default: phase_d = TX_IDLE;
        endcase
    end

    // State registers; reset restarts the power-up wait with pins low
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            phase_q <= TX_PWR;
            cnt_q   <= PWR_LD;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
        end
    end

    assign done_o     = ((phase_q == TX_PWR) || (phase_q == TX_WAIT)) && w_cnt_zero;
    assign lcd_en_o   = (phase_q == TX_EN);
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_frame_writer
//  Description : Initialises a 16x2 HD44780 LCD (8-bit, write-only) and then
//                repeatedly snapshots the two 128-bit ASCII rows and streams
//                them to DDRAM. Column 0 of each row is the MSB byte.
//                Optional macro LCD_CHANGE_ONLY_EN: hold in IDLE until the
//                row inputs differ from the last written snapshot.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int EN_CYC      = 12,
    parameter int CMD_CYC     = 600,
    parameter int CLEAR_CYC   = 24000,
    parameter int POWERUP_CYC = 240000
) (
    input  wire logic      clk,
    input  wire logic      nRst,
    lcd_frame_writer_if.slave bus
);

    state_t         state_q, state_d;
    logic           issue_q, issue_d;       // start this state's byte now
    logic [3:0]     col_q, col_d;
    logic [255:0]   snap_q;
    logic           frame_done_q, frame_done_d;

    logic           w_capture;
    logic           w_go;
    logic           w_start;
    logic           w_rs;
    logic [7:0]     w_data;
    logic           w_long;
    logic           w_done;
    logic [127:0]   w_row;
    logic [7:0]     w_col_byte;

    // Column c of a row sits at bits [8*(15-c) +: 8]; 15-c is ~c for 4 bits
    assign w_row      = (state_q == ST_WR_BOT) ? snap_q[127:0] : snap_q[255:128];
    assign w_col_byte = w_row[{~col_q, 3'b000} +: 8];

`ifdef LCD_CHANGE_ONLY_EN
    logic diff_q;
    logic first_q;

    // Registered change detect against the last written frame
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            diff_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            diff_q  <= ({bus.top, bus.bottom} != snap_q);
            if (w_capture) first_q <= 1'b0;
        end
    end

    assign w_go = first_q | diff_q;
`else
    assign w_go = 1'b1;
`endif

    // Next-state and byte selection; a new byte starts the cycle after done
    always_comb begin
        state_d      = state_q;
        issue_d      = 1'b0;
        col_d        = col_q;
        frame_done_d = 1'b0;
        w_capture    = 1'b0;
        w_start      = issue_q;
        w_rs         = 1'b0;
        w_data       = 8'h00;
        w_long       = 1'b0;
        case (state_q)
            ST_POWERUP: begin
                w_start = 1'b0;
                if (w_done) begin
                    state_d = ST_INIT_FUNC;
                    issue_d = 1'b1;
                end
            end
            ST_INIT_FUNC: begin
                w_data = LCD_FUNC_SET;
                if (w_done) begin
                    state_d = ST_INIT_DISP;
                    issue_d = 1'b1;
                end
            end
            ST_INIT_DISP: begin
                w_data = LCD_DISP_ON;
                if (w_done) begin
                    state_d = ST_INIT_CLEAR;
                    issue_d = 1'b1;
                end
            end
            ST_INIT_CLEAR: begin
                w_data = LCD_CLEAR;
                w_long = 1'b1;
                if (w_done) begin
                    state_d = ST_INIT_ENTRY;
                    issue_d = 1'b1;
                end
            end
            ST_INIT_ENTRY: begin
                w_data = LCD_ENTRY;
                if (w_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // The row-0 address byte is launched from IDLE itself so
                // IDLE doubles as that transaction's start cycle
                w_data  = LCD_ROW0;
                w_start = w_go;
                if (w_go) begin
                    state_d   = ST_ADDR_TOP;
                    w_capture = 1'b1;
                end
            end
            ST_ADDR_TOP: begin
                w_data = LCD_ROW0;
                if (w_done) begin
                    state_d = ST_WR_TOP;
                    issue_d = 1'b1;
                end
            end
            ST_WR_TOP: begin
                w_rs   = 1'b1;
                w_data = w_col_byte;
                if (w_done) begin
                    col_d   = col_q + 4'd1;
                    issue_d = 1'b1;
                    if (col_q == 4'd15) state_d = ST_ADDR_BOT;
                end
            end
            ST_ADDR_BOT: begin
                w_data = LCD_ROW1;
                if (w_done) begin
                    state_d = ST_WR_BOT;
                    issue_d = 1'b1;
                end
            end
            ST_WR_BOT: begin
                w_rs   = 1'b1;
                w_data = w_col_byte;
                if (w_done) begin
                    col_d = col_q + 4'd1;
                    if (col_q == 4'd15) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        issue_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_POWERUP;
                w_start = 1'b0;
            end
        endcase
    end

    // FSM, column counter, frame_done pulse and row snapshot
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= ST_POWERUP;
            issue_q      <= 1'b0;
            col_q        <= 4'd0;
            frame_done_q <= 1'b0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            issue_q      <= issue_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            if (w_capture) snap_q <= {bus.top, bus.bottom};
        end
    end

    lcd_byte_tx #(
        .SETUP_CYC   (SETUP_CYC),
        .EN_CYC      (EN_CYC),
        .CMD_CYC     (CMD_CYC),
        .CLEAR_CYC   (CLEAR_CYC),
        .POWERUP_CYC (POWERUP_CYC)
    ) u_byte_tx (
        .clk         (clk),
        .nRst        (nRst),
        .start_i     (w_start),
        .rs_i        (w_rs),
        .data_i      (w_data),
        .long_wait_i (w_long),
        .done_o      (w_done),
        .lcd_en_o    (bus.lcd_en),
        .lcd_rs_o    (bus.lcd_rs),
        .lcd_data_o  (bus.lcd_data)
    );

    assign bus.lcd_rw     = 1'b0;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_frame_writer
//  Description : Scoreboard bench for lcd_frame_writer with short timing
//                (SETUP=1, EN=2, CMD=4, CLEAR=8, POWERUP=10). Expected LCD
//                writes are queued by the stimulus; a monitor pops one entry
//                per E rising edge and checks RS/DATA/RW and spacing.
//                Honours LCD_CHANGE_ONLY_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_frame_writer;

    logic clk;
    logic nRst;

    lcd_frame_writer_if bus ();

    lcd_frame_writer #(
        .SETUP_CYC   (1),
        .EN_CYC      (2),
        .CMD_CYC     (4),
        .CLEAR_CYC   (8),
        .POWERUP_CYC (10)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;     // cycles since previous E rise, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;

    int   errors = 0;
    int   checks = 0;
    int   cyc;               // cycles since reset release
    int   gcyc = 0;          // free-running cycle count
    int   last_rise = 0;
    int   n_rise = 0;
    int   fd_count = 0;
    int   fd_cyc[8];
    logic en_prev = 1'b0;
    logic fd_prev = 1'b0;
    logic [8:0] hold;

    logic [127:0] HELLO = "   Hello   World";
    logic [127:0] BOT   = {16{8'h5F}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input int gap);
        exp_t e;
        e.rs = rs; e.data = data; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 12);   // power-up 10 + start + setup
        push(1'b0, 8'h0C, 8);
        push(1'b0, 8'h01, 8);
        push(1'b0, 8'h06, 12);   // follows the long clear wait
    endtask

    task automatic push_frame(input logic [127:0] t, input logic [127:0] b, input int g0);
        push(1'b0, 8'h80, g0);
        for (int i = 0; i < 16; i++) push(1'b1, t[127-8*i -: 8], 8);
        push(1'b0, 8'hC0, 8);
        for (int i = 0; i < 16; i++) push(1'b1, b[127-8*i -: 8], 8);
    endtask

    task automatic wait_fd(input int target, input int budget);
        int b;
        b = budget;
        while (fd_count < target && b > 0) begin
            @(posedge clk);
            b--;
        end
        if (fd_count < target) begin
            errors++; checks++;
            $display("FAIL wait_frame_done: got %0d pulses expected %0d", fd_count, target);
        end
    endtask

    task automatic wait_rises(input int target, input int budget);
        int b;
        b = budget;
        while (n_rise < target && b > 0) begin
            @(posedge clk);
            b--;
        end
        if (n_rise < target) begin
            errors++; checks++;
            $display("FAIL wait_e_rise: got %0d rises expected %0d", n_rise, target);
        end
    endtask

    // Cycle counters used for E spacing and frame period
    always @(posedge clk or negedge nRst) begin
        if (!nRst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge clk) gcyc <= gcyc + 1;

    // Monitor: pop-and-compare on every E rise, hold check on E fall
    always @(negedge clk) begin
        if (nRst) begin
            if (bus.lcd_en && !en_prev) begin
                n_rise++;
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_write: got rs=%0b data=%0h expected none",
                             bus.lcd_rs, bus.lcd_data);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("write rw_rs_data_gap",
                          {bus.lcd_rw, bus.lcd_rs, bus.lcd_data, 32'(e_cur.gap == 0 ? 0 : cyc - last_rise)},
                          {1'b0, e_cur.rs, e_cur.data, 32'(e_cur.gap)});
                end
                last_rise = cyc;
                hold = {bus.lcd_rs, bus.lcd_data};
            end
            if (!bus.lcd_en && en_prev)
                check("hold_at_e_fall", {bus.lcd_rs, bus.lcd_data}, hold);
            en_prev = bus.lcd_en;
            if (bus.frame_done) begin
                check("frame_done_single", fd_prev, 1'b0);
                fd_count++;
                if (fd_count < 8) fd_cyc[fd_count] = gcyc;
            end
            fd_prev = bus.frame_done;
        end else begin
            en_prev   = 1'b0;
            fd_prev   = 1'b0;
            last_rise = 0;
        end
    end

    initial begin
        int   base;
        int   bad;
        logic seen;

        nRst       = 1'b0;
        bus.top    = HELLO;
        bus.bottom = BOT;
        repeat (3) @(negedge clk);
        check("reset_pins en_rs_rw_data_busy_fd",
              {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.busy, bus.frame_done},
              {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});

        push_init();
        push_frame(HELLO, BOT, 8);
`ifndef LCD_CHANGE_ONLY_EN
        push_frame(HELLO, BOT, 8);
`endif
        #2 nRst = 1'b1;
        repeat (5) @(negedge clk);
        check("powerup_busy_no_e", {bus.busy, bus.lcd_en}, {1'b1, 1'b0});

        wait_fd(1, 1000);
        base = n_rise;
`ifdef LCD_CHANGE_ONLY_EN
        check("queue_after_frame1", exp_q.size(), 0);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad++;
        end
        check("idle_hold_busy_high_cycles", bad, 0);
        #1 bus.bottom[0] = ~bus.bottom[0];
        push_frame(HELLO, bus.bottom, 0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        check("busy_after_change", seen, 1'b1);
`else
        check("queue_after_frame1", exp_q.size(), 34);
`endif

        // Change column 0 of the top row partway through WR_TOP
        wait_rises(base + 5, 500);
        #1 bus.top[127:120] = 8'h2A;
`ifdef LCD_CHANGE_ONLY_EN
        push_frame(bus.top, bus.bottom, 0);
`else
        push_frame(bus.top, bus.bottom, 8);
        push_frame(bus.top, bus.bottom, 8);
`endif
        wait_fd(2, 1000);
        wait_fd(3, 1000);
`ifdef LCD_CHANGE_ONLY_EN
        #1 bus.bottom[0] = ~bus.bottom[0];
        push_frame(bus.top, bus.bottom, 0);
`else
        check("frame_period_1_2", fd_cyc[2] - fd_cyc[1], 272);
        check("frame_period_2_3", fd_cyc[3] - fd_cyc[2], 272);
`endif

        // Reset while E is high on the second bottom-row data byte
        base = n_rise;
        wait_rises(base + 20, 500);
        check("e_high_before_reset", bus.lcd_en, 1'b1);
        #2 nRst = 1'b0;
        #1 check("reset_drops_e", bus.lcd_en, 1'b0);
        check("reset_pins_mid_frame",
              {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.busy, bus.frame_done},
              {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        push_frame(bus.top, bus.bottom, 8);
        #2 nRst = 1'b1;
        wait_fd(4, 1000);
        check("queue_empty_end", exp_q.size(), 0);
        check("frame_done_count", fd_count, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Drives a 16x2 HD44780-compatible character LCD in 8-bit write-only mode from the two 128-bit ASCII row buffers produced by the host display stage. After power-up it runs the controller init sequence. It then repeatedly snapshots `top`/`bottom` and streams them to DDRAM with all enable-pulse and command-execution delays timed in clock cycles. It sits directly downstream of the host display logic and directly drives the LCD pins.

## Interface
Parameters:
- `SETUP_CYC`, 2, cycles RS/DATA are stable before E rises
- `EN_CYC`, 12, E high width in cycles
- `CMD_CYC`, 600, post-pulse wait for normal commands and data writes
- `CLEAR_CYC`, 24000, post-pulse wait after clear-display (0x01)
- `POWERUP_CYC`, 240000, idle wait after reset before the first command

Ports:
- `clk`  in  1  system clock
- `nRst`  in  1  reset, asynchronous, active-low
- `top`  in  128  row 0 ASCII; `[127:120]` = column 0, `[7:0]` = column 15
- `bottom`  in  128  row 1 ASCII, same byte order
- `lcd_en`  out  1  LCD E
- `lcd_rs`  out  1  LCD RS (0 = command, 1 = data)
- `lcd_rw`  out  1  LCD R/W, tied 0
- `lcd_data`  out  8  LCD DB[7:0]
- `busy`  out  1  high whenever the FSM is not in IDLE
- `frame_done`  out  1  one-cycle pulse after the last byte of row 1 completes

## Operation
- Byte transaction (start/done), for each byte:
  - RS/DATA driven with E=0 for `SETUP_CYC` cycles.
  - E=1 for `EN_CYC` cycles.
  - E=0 with RS/DATA held for the wait count (`CLEAR_CYC` for 0x01, otherwise `CMD_CYC`).
  - `done` pulses on the last wait cycle.
- FSM states: POWERUP → INIT_FUNC (0x38) → INIT_DISP (0x0C) → INIT_CLEAR (0x01) → INIT_ENTRY (0x06) → IDLE → ADDR_TOP (0x80) → WR_TOP (16 data bytes) → ADDR_BOT (0xC0) → WR_BOT (16 data bytes) → IDLE.
- POWERUP lasts `POWERUP_CYC` cycles with all pins at reset values.
- The first frame after init is always written.
- Leaving IDLE captures `top`/`bottom` into a 256-bit snapshot. Input changes during a frame are ignored until the next snapshot.
- Data bytes are sent column 0 first, taken from the snapshot only.
- Column counter is 4-bit. WR_TOP/WR_BOT exit when the counter wraps 15 → 0.

## Timing
- Reset values:
  - `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00
  - `busy`=1
  - `frame_done`=0
  - snapshot=0
  - FSM=POWERUP
- Byte period = `SETUP_CYC`+`EN_CYC`+wait cycles. The next transaction starts exactly 1 cycle after `done`.
- IDLE lasts exactly 1 cycle when a frame is pending.
- `frame_done` is asserted the cycle after the final WR_BOT `done`.
- A frame is 34 transactions. Defaults give 34×614 + 34 = 20910 cycles.
- `nRst` asserted mid-transaction: all outputs return to reset values immediately, and the sequence restarts at POWERUP (full init is repeated).

## Configuration
- `LCD_CHANGE_ONLY_EN`:
  - Defined: IDLE holds (`busy`=0) until `{top,bottom}` differs from the snapshot of the last written frame. Comparison is combinational and registered once, so a frame starts 2 cycles after the change.
  - Undefined: frames run back-to-back and IDLE is always a single cycle.

## Structure
- `lcd_pkg`: FSM state enum; command constants `LCD_FUNC_SET`=0x38, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_ENTRY`=0x06, `LCD_ROW0`=0x80, `LCD_ROW1`=0xC0.
- Sub-module `lcd_byte_tx`:
  - Inputs: `start`, `rs`, `data`, `long_wait`.
  - Outputs: `done`, pins.
  - Owns the single cycle counter.
- Top-level owns the FSM, snapshot and column counter.

## Test plan
Run with `SETUP_CYC`=1, `EN_CYC`=2, `CMD_CYC`=4, `CLEAR_CYC`=8, `POWERUP_CYC`=10.
1. Reset release → no E edge for 10 cycles, then commands 0x38, 0x0C, 0x01, 0x06 (RS=0) are seen on E rising edges, with 8-cycle wait after 0x01.
2. `top`="   Hello   World" pattern, `bottom`=all 0x5F → 0x80, 16 data bytes in column order, 0xC0, 16×0x5F; `frame_done` pulses once.
3. Change `top[127:120]` mid-WR_TOP → current frame writes the old byte; the next frame writes the new byte.
4. Assert `nRst` during E high in WR_BOT → `lcd_en`=0 in the same cycle; after release the full init is repeated.
5. With `LCD_CHANGE_ONLY_EN`, static inputs after the first frame → `busy` stays 0 for 1000 cycles; flip one bit of `bottom` → `busy`=1 within 2 cycles and a full frame is written.
6. Without macro → two consecutive `frame_done` pulses exactly one frame period apart.
